// File: rtl/ama_riscv_decode_queue_pkg.sv
// Shared types, constants and decode reset values for the decode queue slice.
// No logic of its own; provides the dec_q_entry_t payload stored per queue entry.
// Optional feature: AMA_RISCV_DEC_ILLEGAL_EN adds an illegal bit to each entry.
`ifndef AMA_RISCV_DECODE_DEFINES
`define AMA_RISCV_DECODE_DEFINES
`define DECODER_RST_VAL ama_riscv_decode_queue_pkg::DECODER_RST
`define FE_CTRL_RST_VAL ama_riscv_decode_queue_pkg::FE_CTRL_RST
`endif

package ama_riscv_decode_queue_pkg;

  localparam int ARCH_W = 32;
  typedef logic [ARCH_W-1:0] arch_width_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b1111;

  typedef enum logic {ALU_A_RS1, ALU_A_PC} alu_a_sel_t;
  typedef enum logic {ALU_B_RS2, ALU_B_IMM} alu_b_sel_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_t;
  typedef enum logic [1:0] {PC_SEL_INC4, PC_SEL_ALU, PC_SEL_BR} pc_sel_t;

  typedef struct packed {
    logic [3:0] alu_op;
    alu_a_sel_t alu_a_sel;
    alu_b_sel_t alu_b_sel;
    imm_sel_t   imm_sel;
    logic       rd_we;
    logic       dmem_en;
    logic       dmem_we;
    wb_sel_t    wb_sel;
    logic       branch_inst;
    logic       jump_inst;
    logic       csr_en;
  } decoder_t;

  typedef struct packed {
    pc_sel_t pc_sel;
    logic    pc_we;
  } fe_ctrl_t;

  typedef struct packed {
    decoder_t    decoded;
    fe_ctrl_t    fe_ctrl;
    arch_width_t inst;
    arch_width_t pc;
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    logic        illegal;
`endif
  } dec_q_entry_t;

  localparam decoder_t DECODER_RST = '{
    alu_op: ALU_ADD, alu_a_sel: ALU_A_RS1, alu_b_sel: ALU_B_RS2, imm_sel: IMM_I,
    rd_we: 1'b0, dmem_en: 1'b0, dmem_we: 1'b0, wb_sel: WB_ALU,
    branch_inst: 1'b0, jump_inst: 1'b0, csr_en: 1'b0};

  localparam fe_ctrl_t FE_CTRL_RST = '{pc_sel: PC_SEL_INC4, pc_we: 1'b0};

  // True when the major opcode belongs to a class the decoder understands
  function automatic logic opc_supported(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ama_riscv_decoder.sv
// Single-instruction combinational decode into datapath and frontend control.
// Latency: zero cycles (pure combinational).
// Backpressure: none; unknown opcodes and SYSTEM fn3==0 yield the reset decode.
module ama_riscv_decoder
  import ama_riscv_decode_queue_pkg::*;
(
  input  arch_width_t inst,
  output decoder_t    decoded,
  output fe_ctrl_t    fe_ctrl
);

  logic [6:0] opc7;
  logic [2:0] fn3;
  logic       fn7_b5;
  logic       unused_bits;

  assign opc7        = inst[6:0];
  assign fn3         = inst[14:12];
  assign fn7_b5      = inst[30];
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  // Per-class control; anything not matched keeps the reset decode (NOP)
  always_comb begin
    decoded = `DECODER_RST_VAL;
    fe_ctrl = `FE_CTRL_RST_VAL;
    case (opc7)
      OPC_LUI: begin
        decoded.alu_op = ALU_PASS_B; decoded.alu_b_sel = ALU_B_IMM;
        decoded.imm_sel = IMM_U; decoded.rd_we = 1'b1; fe_ctrl.pc_we = 1'b1;
      end
      OPC_AUIPC: begin
        decoded.alu_a_sel = ALU_A_PC; decoded.alu_b_sel = ALU_B_IMM;
        decoded.imm_sel = IMM_U; decoded.rd_we = 1'b1; fe_ctrl.pc_we = 1'b1;
      end
      OPC_JAL: begin
        decoded.alu_a_sel = ALU_A_PC; decoded.alu_b_sel = ALU_B_IMM;
        decoded.imm_sel = IMM_J; decoded.rd_we = 1'b1; decoded.wb_sel = WB_PC4;
        decoded.jump_inst = 1'b1; fe_ctrl.pc_sel = PC_SEL_ALU; fe_ctrl.pc_we = 1'b1;
      end
      OPC_JALR: begin
        decoded.alu_b_sel = ALU_B_IMM; decoded.imm_sel = IMM_I;
        decoded.rd_we = 1'b1; decoded.wb_sel = WB_PC4; decoded.jump_inst = 1'b1;
        fe_ctrl.pc_sel = PC_SEL_ALU; fe_ctrl.pc_we = 1'b1;
      end
      OPC_BRANCH: begin
        decoded.alu_a_sel = ALU_A_PC; decoded.alu_b_sel = ALU_B_IMM;
        decoded.imm_sel = IMM_B; decoded.branch_inst = 1'b1;
        fe_ctrl.pc_sel = PC_SEL_BR; fe_ctrl.pc_we = 1'b1;
      end
      OPC_LOAD: begin
        decoded.alu_b_sel = ALU_B_IMM; decoded.imm_sel = IMM_I; decoded.rd_we = 1'b1;
        decoded.dmem_en = 1'b1; decoded.wb_sel = WB_MEM; fe_ctrl.pc_we = 1'b1;
      end
      OPC_STORE: begin
        decoded.alu_b_sel = ALU_B_IMM; decoded.imm_sel = IMM_S;
        decoded.dmem_en = 1'b1; decoded.dmem_we = 1'b1; fe_ctrl.pc_we = 1'b1;
      end
      OPC_OP_IMM: begin
        decoded.alu_op = {(fn3 == 3'b101) && fn7_b5, fn3};
        decoded.alu_b_sel = ALU_B_IMM; decoded.imm_sel = IMM_I;
        decoded.rd_we = 1'b1; fe_ctrl.pc_we = 1'b1;
      end
      OPC_OP: begin
        decoded.alu_op = {fn7_b5, fn3}; decoded.rd_we = 1'b1; fe_ctrl.pc_we = 1'b1;
      end
      OPC_MISC_MEM: fe_ctrl.pc_we = 1'b1;
      OPC_SYSTEM: begin
        if (fn3 != 3'b000) begin
          decoded.rd_we = 1'b1; decoded.wb_sel = WB_CSR; decoded.csr_en = 1'b1;
          fe_ctrl.pc_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ama_riscv_sync_fifo.sv
// Generic DEPTH-entry synchronous FIFO of type T with occupancy count and flush.
// Latency: one cycle from push to head visibility; head read combinationally from storage.
// Backpressure: caller gates push/pop; flush and reset drop any same-cycle push/pop.
module ama_riscv_sync_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         wr_dat,
  input  logic                     pop,
  output T                         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_dat = mem[rd_ptr];

  // Pointer and count update; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage; not reset since entries are only read while counted
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/ama_riscv_decode_queue.sv
// Decode stage: decodes fetched instructions and buffers them in a DEPTH-entry queue.
// Latency: one cycle push-to-head, no input-to-output bypass; flush empties in one cycle.
// Backpressure: in_ready drops when full unless the head is popped the same cycle.
// Optional feature: AMA_RISCV_DEC_ILLEGAL_EN adds per-entry illegal flag and out_illegal.
module ama_riscv_decode_queue
  import ama_riscv_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  arch_width_t      in_inst,
  input  arch_width_t      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output decoder_t         out_decoded,
  output fe_ctrl_t         out_fe_ctrl,
  output arch_width_t      out_inst,
  output arch_width_t      out_pc,
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
  output logic             out_illegal,
`endif
  output logic [CNT_W-1:0] occupancy
);

  logic         push;
  logic         pop;
  decoder_t     dec;
  fe_ctrl_t     fe;
  dec_q_entry_t wr_entry;
  dec_q_entry_t rd_entry;
  arch_width_t  last_inst;
  arch_width_t  last_pc;

  assign out_valid = (occupancy != '0);
  assign in_ready  = !rst && ((occupancy < CNT_W'(DEPTH)) || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  ama_riscv_decoder u_decoder (
    .inst    (in_inst),
    .decoded (dec),
    .fe_ctrl (fe)
  );

  // Assemble the stored payload; flagged illegal entries never redirect fetch
  always_comb begin
    wr_entry         = '0;
    wr_entry.decoded = dec;
    wr_entry.fe_ctrl = fe;
    wr_entry.inst    = in_inst;
    wr_entry.pc      = in_pc;
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    wr_entry.illegal = !opc_supported(in_inst[6:0]) ||
                       ((in_inst[6:0] == OPC_SYSTEM) && (in_inst[14:12] == 3'b000));
    if (wr_entry.illegal) wr_entry.fe_ctrl.pc_we = 1'b0;
`endif
  end

  ama_riscv_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (dec_q_entry_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .wr_dat (wr_entry),
    .pop    (pop),
    .rd_dat (rd_entry),
    .count  (occupancy)
  );

  // Remember the last presented inst/pc so they hold steady while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      last_inst <= '0;
      last_pc   <= '0;
    end else if (out_valid) begin
      last_inst <= rd_entry.inst;
      last_pc   <= rd_entry.pc;
    end
  end

  // Head presentation; empty queue shows reset control so stale entries never leak
  always_comb begin
    out_decoded = `DECODER_RST_VAL;
    out_fe_ctrl = `FE_CTRL_RST_VAL;
    out_inst    = last_inst;
    out_pc      = last_pc;
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    out_illegal = 1'b0;
`endif
    if (out_valid) begin
      out_decoded = rd_entry.decoded;
      out_fe_ctrl = rd_entry.fe_ctrl;
      out_inst    = rd_entry.inst;
      out_pc      = rd_entry.pc;
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
      out_illegal = rd_entry.illegal;
`endif
    end
  end

endmodule

// File: tb/tb_ama_riscv_decode_queue.sv
// Self-checking bench for ama_riscv_decode_queue: directed scenarios plus randomized traffic.
// Expected values come from an opcode table and a queue-based model of the buffer.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_ama_riscv_decode_queue;
  import ama_riscv_decode_queue_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  arch_width_t      in_inst = '0;
  arch_width_t      in_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  decoder_t         out_decoded;
  fe_ctrl_t         out_fe_ctrl;
  arch_width_t      out_inst;
  arch_width_t      out_pc;
  logic [CNT_W-1:0] occupancy;
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
  logic             out_illegal;
`endif

  ama_riscv_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_decoded(out_decoded),
    .out_fe_ctrl(out_fe_ctrl), .out_inst(out_inst), .out_pc(out_pc),
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    decoder_t    d;
    fe_ctrl_t    f;
    arch_width_t inst;
    arch_width_t pc;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  arch_width_t last_inst = '0;
  arch_width_t last_pc = '0;

  // Opcode class table: what each supported class must produce
  logic [6:0] t_opc [11];
  decoder_t   t_dec [11];
  pc_sel_t    t_ps  [11];

  function automatic decoder_t mkd(input logic [3:0] op, input alu_a_sel_t a, input alu_b_sel_t b,
                                   input imm_sel_t im, input logic rw, input logic den, input logic dwe,
                                   input wb_sel_t wb, input logic br, input logic jmp, input logic csr);
    decoder_t d;
    d.alu_op = op; d.alu_a_sel = a; d.alu_b_sel = b; d.imm_sel = im; d.rd_we = rw;
    d.dmem_en = den; d.dmem_we = dwe; d.wb_sel = wb; d.branch_inst = br; d.jump_inst = jmp;
    d.csr_en = csr;
    return d;
  endfunction

  task automatic init_table();
    t_opc[0]  = 7'h37; t_dec[0]  = mkd(4'hF, ALU_A_RS1, ALU_B_IMM, IMM_U, 1, 0, 0, WB_ALU, 0, 0, 0); t_ps[0]  = PC_SEL_INC4;
    t_opc[1]  = 7'h17; t_dec[1]  = mkd(4'h0, ALU_A_PC,  ALU_B_IMM, IMM_U, 1, 0, 0, WB_ALU, 0, 0, 0); t_ps[1]  = PC_SEL_INC4;
    t_opc[2]  = 7'h6F; t_dec[2]  = mkd(4'h0, ALU_A_PC,  ALU_B_IMM, IMM_J, 1, 0, 0, WB_PC4, 0, 1, 0); t_ps[2]  = PC_SEL_ALU;
    t_opc[3]  = 7'h67; t_dec[3]  = mkd(4'h0, ALU_A_RS1, ALU_B_IMM, IMM_I, 1, 0, 0, WB_PC4, 0, 1, 0); t_ps[3]  = PC_SEL_ALU;
    t_opc[4]  = 7'h63; t_dec[4]  = mkd(4'h0, ALU_A_PC,  ALU_B_IMM, IMM_B, 0, 0, 0, WB_ALU, 1, 0, 0); t_ps[4]  = PC_SEL_BR;
    t_opc[5]  = 7'h03; t_dec[5]  = mkd(4'h0, ALU_A_RS1, ALU_B_IMM, IMM_I, 1, 1, 0, WB_MEM, 0, 0, 0); t_ps[5]  = PC_SEL_INC4;
    t_opc[6]  = 7'h23; t_dec[6]  = mkd(4'h0, ALU_A_RS1, ALU_B_IMM, IMM_S, 0, 1, 1, WB_ALU, 0, 0, 0); t_ps[6]  = PC_SEL_INC4;
    t_opc[7]  = 7'h13; t_dec[7]  = mkd(4'h0, ALU_A_RS1, ALU_B_IMM, IMM_I, 1, 0, 0, WB_ALU, 0, 0, 0); t_ps[7]  = PC_SEL_INC4;
    t_opc[8]  = 7'h33; t_dec[8]  = mkd(4'h0, ALU_A_RS1, ALU_B_RS2, IMM_I, 1, 0, 0, WB_ALU, 0, 0, 0); t_ps[8]  = PC_SEL_INC4;
    t_opc[9]  = 7'h0F; t_dec[9]  = mkd(4'h0, ALU_A_RS1, ALU_B_RS2, IMM_I, 0, 0, 0, WB_ALU, 0, 0, 0); t_ps[9]  = PC_SEL_INC4;
    t_opc[10] = 7'h73; t_dec[10] = mkd(4'h0, ALU_A_RS1, ALU_B_RS2, IMM_I, 1, 0, 0, WB_CSR, 0, 0, 1); t_ps[10] = PC_SEL_INC4;
  endtask

  // Expected stored entry for an instruction: table lookup plus ALU-op rule
  function automatic exp_t model_entry(input arch_width_t inst, input arch_width_t pc);
    exp_t e;
    logic [6:0] opc = inst[6:0];
    logic [2:0] fn3 = inst[14:12];
    e.d = DECODER_RST; e.f = FE_CTRL_RST; e.inst = inst; e.pc = pc; e.ill = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (t_opc[i] == opc && !(opc == 7'h73 && fn3 == 3'd0)) begin
        e.d = t_dec[i]; e.f.pc_sel = t_ps[i]; e.f.pc_we = 1'b1; e.ill = 1'b0;
      end
    end
    if (opc == 7'h33) e.d.alu_op = {inst[30], fn3};
    if (opc == 7'h13) e.d.alu_op = {(fn3 == 3'd5) ? inst[30] : 1'b0, fn3};
    return e;
  endfunction

  // Drive one cycle's inputs on the falling edge, then let outputs settle
  task automatic apply(input logic fl, input logic iv, input logic orr,
                       input arch_width_t inst, input arch_width_t pc);
    @(negedge clk);
    flush = fl; in_valid = iv; out_ready = orr; in_inst = inst; in_pc = pc;
    #1;
  endtask

  // Clock edge plus model update from the inputs the bench itself drove
  task automatic commit();
    bit exp_push, exp_pop;
    exp_push = in_valid && !rst && ((q.size() < DEPTH) || out_ready);
    exp_pop  = (q.size() != 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      q.delete(); last_inst = '0; last_pc = '0;
    end else begin
      if (q.size() != 0) begin last_inst = q[0].inst; last_pc = q[0].pc; end
      if (flush) q.delete();
      else begin
        if (exp_pop) void'(q.pop_front());
        if (exp_push) q.push_back(model_entry(in_inst, in_pc));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(0, 1, 1, 32'h00500093, 32'h0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    commit();
    apply(0, 0, 0, '0, '0);
    commit();
    rst = 1'b0;
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_decoded !== DECODER_RST) begin n_err++; $display("FAIL reset_decoded: got %h want %h", out_decoded, DECODER_RST); end
    n_cmp++; if (out_fe_ctrl !== FE_CTRL_RST) begin n_err++; $display("FAIL reset_fe_ctrl: got %h want %h", out_fe_ctrl, FE_CTRL_RST); end
    n_cmp++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc: got %h/%h want 0/0", out_inst, out_pc); end
    commit();
  endtask

  task automatic test_single();
    apply(0, 1, 0, 32'h00500093, 32'h100);
    commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h100) begin n_err++; $display("FAIL single_pc: got %h want 100", out_pc); end
    n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    n_cmp++; if (out_decoded.alu_b_sel !== ALU_B_IMM || out_decoded.rd_we !== 1'b1)
      begin n_err++; $display("FAIL single_decode: got b_sel %0d rd_we %b want 1/1", out_decoded.alu_b_sel, out_decoded.rd_we); end
    commit();
    apply(0, 0, 1, '0, '0);
    commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got occ %0d vld %b want 0/0", occupancy, out_valid); end
    n_cmp++; if (out_decoded !== DECODER_RST) begin n_err++; $display("FAIL empty_forced_decode: got %h want %h", out_decoded, DECODER_RST); end
    n_cmp++; if (out_pc !== 32'h100 || out_inst !== 32'h00500093) begin n_err++; $display("FAIL empty_hold: got %h/%h want 00500093/100", out_inst, out_pc); end
    commit();
  endtask

  task automatic test_fill_and_full_push_pop();
    apply(0, 1, 0, 32'h002081B3, 32'h200); commit();
    apply(0, 1, 0, 32'h0000A283, 32'h204);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_2nd: got %b want 1", in_ready); end
    commit();
    apply(0, 1, 0, 32'h0050A223, 32'h208);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_full: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL fill_occ: got %0d want 2", occupancy); end
    n_cmp++; if (out_pc !== 32'h200) begin n_err++; $display("FAIL fill_order: got %h want 200", out_pc); end
    commit();
    apply(0, 1, 1, 32'h0050A223, 32'h208);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ready: got %b want 1", in_ready); end
    commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (occupancy !== 2'd2 || out_pc !== 32'h204) begin n_err++; $display("FAIL full_pushpop_head: got occ %0d pc %h want 2/204", occupancy, out_pc); end
    n_cmp++; if (out_decoded.wb_sel !== WB_MEM) begin n_err++; $display("FAIL load_wb_sel: got %0d want %0d", out_decoded.wb_sel, WB_MEM); end
    commit();
    apply(0, 0, 1, '0, '0); commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (out_pc !== 32'h208 || out_inst !== 32'h0050A223 || occupancy !== 2'd1)
      begin n_err++; $display("FAIL wrapped_entry: got pc %h inst %h occ %0d want 208/0050a223/1", out_pc, out_inst, occupancy); end
    n_cmp++; if (out_decoded.dmem_we !== 1'b1) begin n_err++; $display("FAIL store_dmem_we: got %b want 1", out_decoded.dmem_we); end
    commit();
  endtask

  task automatic test_flush();
    apply(0, 1, 0, 32'h00208463, 32'h20C); commit();
    apply(1, 1, 0, 32'h008000EF, 32'h210); commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got occ %0d vld %b want 0/0", occupancy, out_valid); end
    commit();
    apply(0, 1, 0, 32'h123450B7, 32'h300); commit();
    apply(0, 0, 0, '0, '0);
    n_cmp++; if (occupancy !== 2'd1 || out_pc !== 32'h300) begin n_err++; $display("FAIL flush_dropped_push: got occ %0d pc %h want 1/300", occupancy, out_pc); end
    commit();
    apply(0, 0, 1, '0, '0); commit();
  endtask

  task automatic test_illegal();
    apply(0, 1, 0, 32'h0000007F, 32'h400); commit();
    apply(0, 1, 0, 32'h00000073, 32'h404);
    n_cmp++; if (out_decoded.rd_we !== 1'b0 || out_fe_ctrl.pc_we !== 1'b0)
      begin n_err++; $display("FAIL illegal_we: got rd_we %b pc_we %b want 0/0", out_decoded.rd_we, out_fe_ctrl.pc_we); end
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL illegal_flag: got %b want 1", out_illegal); end
`else
    n_cmp++; if (out_decoded !== DECODER_RST || out_fe_ctrl !== FE_CTRL_RST)
      begin n_err++; $display("FAIL illegal_nop: got %h/%h want %h/%h", out_decoded, out_fe_ctrl, DECODER_RST, FE_CTRL_RST); end
`endif
    commit();
    apply(0, 0, 1, '0, '0);
    commit();
    apply(0, 0, 1, '0, '0);
    n_cmp++; if (out_pc !== 32'h404 || out_fe_ctrl.pc_we !== 1'b0) begin n_err++; $display("FAIL ecall_entry: got pc %h pc_we %b want 404/0", out_pc, out_fe_ctrl.pc_we); end
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
    n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ecall_flag: got %b want 1", out_illegal); end
`endif
    commit();
  endtask

  function automatic arch_width_t rand_inst();
    arch_width_t inst;
    int c;
    logic [6:0] bad [5];
    bad[0] = 7'h7F; bad[1] = 7'h00; bad[2] = 7'h0B; bad[3] = 7'h5B; bad[4] = 7'h2F;
    inst = $urandom;
    c = $urandom_range(0, 13);
    if (c <= 10) inst[6:0] = t_opc[c];
    else if (c == 11) begin inst[6:0] = 7'h73; inst[14:12] = 3'd0; end
    else inst[6:0] = bad[$urandom_range(0, 4)];
    if (c == 10) inst[14:12] = 3'($urandom_range(1, 7));
    return inst;
  endfunction

  task automatic test_random();
    logic [CNT_W-1:0] exp_occ;
    logic exp_rdy;
    for (int cyc = 0; cyc < 600; cyc++) begin
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
            rand_inst(), arch_width_t'($urandom) & ~32'h3);
      exp_occ = CNT_W'(q.size());
      exp_rdy = (q.size() < DEPTH) || out_ready;
      n_cmp++; if (occupancy !== exp_occ) begin n_err++; $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, occupancy, exp_occ); end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, q.size() != 0); end
      n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      if (q.size() != 0) begin
        n_cmp++;
        if (out_decoded !== q[0].d || out_fe_ctrl !== q[0].f || out_inst !== q[0].inst || out_pc !== q[0].pc)
          begin n_err++; $display("FAIL rnd_head c%0d: got %h %h %h %h want %h %h %h %h", cyc, out_decoded, out_fe_ctrl,
                                  out_inst, out_pc, q[0].d, q[0].f, q[0].inst, q[0].pc); end
`ifdef AMA_RISCV_DEC_ILLEGAL_EN
        n_cmp++; if (out_illegal !== q[0].ill) begin n_err++; $display("FAIL rnd_illegal c%0d: got %b want %b", cyc, out_illegal, q[0].ill); end
`endif
      end else begin
        n_cmp++;
        if (out_decoded !== DECODER_RST || out_fe_ctrl !== FE_CTRL_RST || out_inst !== last_inst || out_pc !== last_pc)
          begin n_err++; $display("FAIL rnd_empty c%0d: got %h %h %h %h want %h %h %h %h", cyc, out_decoded, out_fe_ctrl,
                                  out_inst, out_pc, DECODER_RST, FE_CTRL_RST, last_inst, last_pc); end
      end
      commit();
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_single();
    test_fill_and_full_push_pop();
    test_flush();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ama_riscv_decode_queue.md
Name: ama_riscv_decode_queue

Overview:
Parametrised decode stage with buffering. It sits between fetch and the operand/issue stage.
- Each accepted instruction is decoded with the core's existing single-instruction combinational decode (ama_riscv_decoder).
- The result is stored in a DEPTH-entry FIFO together with its PC and raw instruction word.
- Both sides use valid/ready handshakes, so fetch can keep running while the back end stalls.
- Flush from branch/jump resolution empties the queue in one cycle.

Parameters:
DEPTH, 2, number of decoded-op entries; power of two, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter; derived, not overridden.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries and any push in the same cycle
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept this cycle
in_inst  in  arch_width_t  raw instruction word
in_pc  in  arch_width_t  PC of in_inst
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes the head
out_decoded  out  decoder_t  decoded control of the head
out_fe_ctrl  out  fe_ctrl_t  frontend control of the head
out_inst  out  arch_width_t  raw word of the head
out_pc  out  arch_width_t  PC of the head
occupancy  out  CNT_W  current entry count, 0..DEPTH

Behaviour:
Reset values:
- Reset is synchronous and active-high: rst sampled high at a clk edge clears the queue.
- After reset: count=0, rd_ptr=wr_ptr=0, out_valid=0, occupancy=0.
- out_decoded=`DECODER_RST_VAL, out_fe_ctrl=`FE_CTRL_RST_VAL, out_inst=0, out_pc=0.

Handshake:
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count<DEPTH) | out_ready, so push is allowed when full if a pop happens the same cycle. in_ready is 0 during rst.
- out_valid = (count!=0).
- out_* are driven from the head entry register. They are not combinational from in_*, so there is no in-to-out bypass.

Latency:
- An instruction pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- Decode happens before storage. Storage payload is decoder_t, fe_ctrl_t, inst and pc.

Counter and pointers:
- Pointers are log2(DEPTH) bits and wrap naturally.
- count +1 on push only, -1 on pop only, unchanged on push+pop.
- push+pop when full is legal.
- push+pop when empty is impossible, since out_valid=0.

Flush:
- flush has priority over push and pop.
- Next cycle: count=0, pointers reset, out_valid=0.
- A handshake asserted in the flush cycle is dropped.

Head entry when empty:
- When count==0, out_decoded/out_fe_ctrl are forced to the RST_VAL constants.
- When count==0, out_inst/out_pc hold their last value. The consumer must qualify with out_valid.

Other rules:
- X-safety: unwritten entries are never presented while out_valid=1.
- No state machine beyond the count: the states are EMPTY (count==0), PARTIAL and FULL (count==DEPTH), all derived from count.
- Unknown opcode: the entry stores the RST_VAL decode, which leaves all write enables low (unless the optional feature below is compiled in).

Optional Feature:
Macro: AMA_RISCV_DEC_ILLEGAL_EN.
- When defined:
  - Each entry carries an extra illegal bit.
  - The bit is set when opc7 matches no supported opcode class, or when a SYSTEM instruction has fn3==0.
  - The bit is exposed on an added port out_illegal (out, 1, reset 0).
  - For a flagged entry, out_fe_ctrl.pc_we is forced 0.
- When undefined:
  - There is no port and no storage.
  - Such instructions pass through as the RST_VAL decode, which behaves as a NOP.

Decomposition:
- Shared package / defines: decoder_t, fe_ctrl_t, arch_width_t, `DECODER_RST_VAL, `FE_CTRL_RST_VAL.
- Also in the package: a new typedef dec_q_entry_t = {decoder_t, fe_ctrl_t, inst, pc[, illegal]}.
- One natural sub-module: ama_riscv_sync_fifo, a generic DEPTH×dec_q_entry_t FIFO with count and flush.
- The top level instantiates the decoder plus this FIFO and adds the empty-head forcing.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles → out_valid=0, occupancy=0, in_ready=1 and out_decoded==`DECODER_RST_VAL after release.
2. Single push/pop: push ADDI x1,x0,5 (0x00500093, pc 0x100) with out_ready=0 → next cycle out_valid=1, out_pc=0x100, occupancy=1, alu_b_sel=IMM, rd_we=1; then out_ready=1 → occupancy=0.
3. Fill with DEPTH=2 and out_ready=0: push 3 instructions → in_ready=0 after the 2nd, the 3rd is held by fetch, occupancy=2, order preserved.
4. Full push+pop: at count=2, in_valid=1 and out_ready=1 → occupancy stays 2, head advances, the new entry is written at the wrapped pointer.
5. Flush with simultaneous push: count=2, flush=1, in_valid=1 → next cycle occupancy=0, out_valid=0, the pushed instruction is not stored.
6. Illegal instruction (macro on): push 0x0000007F → out_illegal=1, rd_we=0, pc_we=0. With the macro off, the same push gives a RST_VAL decode.
